pipeline_ctrl: RTL and testbench

- Hazard and sequencing controller for the 5-stage RV32I pipeline. Drives stage write-enables, bubbles and flushes, and the EX operand-forwarding selects that feed the ALU.
- Consumes the ALU's taken-branch/jump indication and target, and a data-memory ready handshake.
- Resolves load-use stalls, memory wait freezes and control-flow redirects in a single FSM with fixed priority.

---
 rtl/pipe_ctrl_pkg.sv | 17 +
 rtl/fwd_unit.sv | 30 +++
 rtl/pipeline_ctrl.sv | 148 ++++++++++++++
 tb/tb_pipeline_ctrl.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_ctrl_pkg.sv
// Shared encodings for the RV32I pipeline hazard controller.
// Holds the FSM states, the ALU operand-forwarding selects and the x0 register index.
package pipe_ctrl_pkg;

   typedef enum logic [1:0] {
      RUN      = 2'd0,
      LU_STALL = 2'd1,
      MEM_WAIT = 2'd2
   } state_e;

   localparam logic [1:0] FWD_RF  = 2'b00;
   localparam logic [1:0] FWD_WB  = 2'b01;
   localparam logic [1:0] FWD_MEM = 2'b10;

   localparam logic [4:0] REG_ZERO = 5'd0;

endpackage

// File: rtl/fwd_unit.sv
// EX operand-forwarding comparators. Purely combinational, with no backpressure.
// EX/MEM wins over MEM/WB because it holds the younger write to the same register.
module fwd_unit
   import pipe_ctrl_pkg::*;
(
   input  logic [4:0] ex_rs1,
   input  logic [4:0] ex_rs2,
   input  logic [4:0] mem_rd,
   input  logic       mem_reg_write,
   input  logic [4:0] wb_rd,
   input  logic       wb_reg_write,
   output logic [1:0] fwd_a,
   output logic [1:0] fwd_b
);

   always_comb begin
      fwd_a = FWD_RF;
      if (mem_reg_write && mem_rd != REG_ZERO && mem_rd == ex_rs1)
         fwd_a = FWD_MEM;
      else if (wb_reg_write && wb_rd != REG_ZERO && wb_rd == ex_rs1)
         fwd_a = FWD_WB;

      fwd_b = FWD_RF;
      if (mem_reg_write && mem_rd != REG_ZERO && mem_rd == ex_rs2)
         fwd_b = FWD_MEM;
      else if (wb_reg_write && wb_rd != REG_ZERO && wb_rd == ex_rs2)
         fwd_b = FWD_WB;
   end

endmodule

// File: rtl/pipeline_ctrl.sv
// 5-stage pipeline hazard/sequencing controller. Stage controls respond in the same cycle (comb from state + inputs);
// a memory wait freezes every stage register. Define PIPE_PERF_CNT_EN to add the performance counters.
module pipeline_ctrl
   import pipe_ctrl_pkg::*;
#(
   parameter int unsigned MEM_TIMEOUT = 255,
   parameter int unsigned CNT_W       = 32
)(
   input  logic              clk,
   input  logic              rst_n,
   input  logic [4:0]        id_rs1,
   input  logic [4:0]        id_rs2,
   input  logic              id_uses_rs1,
   input  logic              id_uses_rs2,
   input  logic [4:0]        ex_rs1,
   input  logic [4:0]        ex_rs2,
   input  logic [4:0]        ex_rd,
   input  logic              ex_reg_write,
   input  logic              ex_is_load,
   input  logic [4:0]        mem_rd,
   input  logic [4:0]        wb_rd,
   input  logic              mem_reg_write,
   input  logic              wb_reg_write,
   input  logic              mem_access,
   input  logic              dmem_ready,
   input  logic              ex_branch,
   input  logic [31:0]       ex_pc_branch,
   output logic              pc_write,
   output logic              if_id_write,
   output logic              id_ex_write,
   output logic              ex_mem_write,
   output logic              mem_wb_write,
   output logic              if_id_flush,
   output logic              id_ex_flush,
   output logic              pc_sel,
   output logic [31:0]       pc_target,
   output logic [1:0]        fwd_a,
   output logic [1:0]        fwd_b,
   output logic [1:0]        stall_state,
   output logic              mem_timeout
`ifdef PIPE_PERF_CNT_EN
   ,
   output logic [CNT_W-1:0]  perf_stall_cycles,
   output logic [CNT_W-1:0]  perf_flushes,
   output logic [CNT_W-1:0]  perf_mem_wait
`endif
);

   localparam logic [7:0] TIMEOUT_MAX = 8'(MEM_TIMEOUT);

   state_e      state_q, state_d;
   logic [7:0]  wait_cnt_q, wait_cnt_d;
   logic        timeout_q, timeout_d;
   logic [31:0] pc_target_q, pc_target_d;
   logic        mem_wait, load_use, freeze, redirect, lu_stall;

   fwd_unit u_fwd (
      .ex_rs1        (ex_rs1),
      .ex_rs2        (ex_rs2),
      .mem_rd        (mem_rd),
      .mem_reg_write (mem_reg_write),
      .wb_rd         (wb_rd),
      .wb_reg_write  (wb_reg_write),
      .fwd_a         (fwd_a),
      .fwd_b         (fwd_b)
   );

   assign mem_wait = mem_access && !dmem_ready;
   assign load_use = ex_is_load && ex_reg_write && ex_rd != REG_ZERO &&
                     ((id_uses_rs1 && id_rs1 == ex_rd) || (id_uses_rs2 && id_rs2 == ex_rd));

   always_comb begin
      // Once waiting, only dmem_ready releases the freeze; EX is re-evaluated in the release cycle.
      freeze   = (state_q == MEM_WAIT) ? !dmem_ready : mem_wait;
      redirect = !freeze && ex_branch;
      lu_stall = !freeze && !redirect && load_use && (state_q != LU_STALL);

      if (freeze)
         state_d = MEM_WAIT;
      else if (lu_stall)
         state_d = LU_STALL;
      else
         state_d = RUN;

      wait_cnt_d = '0;
      if (freeze)
         wait_cnt_d = (wait_cnt_q >= TIMEOUT_MAX) ? wait_cnt_q : wait_cnt_q + 8'd1;
      timeout_d   = timeout_q || (wait_cnt_d == TIMEOUT_MAX);
      pc_target_d = redirect ? ex_pc_branch : pc_target_q;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= RUN;
         wait_cnt_q  <= '0;
         timeout_q   <= 1'b0;
         pc_target_q <= '0;
      end else begin
         state_q     <= state_d;
         wait_cnt_q  <= wait_cnt_d;
         timeout_q   <= timeout_d;
         pc_target_q <= pc_target_d;
      end
   end

   // Reset forces the run-mode defaults straight onto the outputs, whatever the inputs do.
   assign pc_write     = !rst_n || (!freeze && !lu_stall);
   assign if_id_write  = !rst_n || (!freeze && !lu_stall);
   assign id_ex_write  = !rst_n || !freeze;
   assign ex_mem_write = !rst_n || !freeze;
   assign mem_wb_write = !rst_n || !freeze;
   assign if_id_flush  = rst_n && redirect;
   assign id_ex_flush  = rst_n && (redirect || lu_stall);
   assign pc_sel       = rst_n && redirect;
   assign pc_target    = !rst_n ? 32'd0 : (redirect ? ex_pc_branch : pc_target_q);
   assign stall_state  = state_q;
   assign mem_timeout  = timeout_q;

`ifdef PIPE_PERF_CNT_EN
   logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
   logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;
   logic [CNT_W-1:0] memw_cnt_q,  memw_cnt_d;

   // Counters observe only the outputs so they stay independent of the FSM internals.
   always_comb begin
      stall_cnt_d = stall_cnt_q + CNT_W'(!pc_write);
      flush_cnt_d = flush_cnt_q + CNT_W'(pc_sel);
      memw_cnt_d  = memw_cnt_q  + CNT_W'(stall_state == MEM_WAIT);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         stall_cnt_q <= '0;
         flush_cnt_q <= '0;
         memw_cnt_q  <= '0;
      end else begin
         stall_cnt_q <= stall_cnt_d;
         flush_cnt_q <= flush_cnt_d;
         memw_cnt_q  <= memw_cnt_d;
      end
   end

   assign perf_stall_cycles = stall_cnt_q;
   assign perf_flushes      = flush_cnt_q;
   assign perf_mem_wait     = memw_cnt_q;
`endif

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Self-checking bench for pipeline_ctrl: forwarding vector table, directed hazard/wait/timeout/reset
// sequences, then randomized traffic compared against a cycle-level reference model.
module tb_pipeline_ctrl;

   localparam int TMO = 4;

   // {pc_write, if_id_write, id_ex_write, ex_mem_write, mem_wb_write, if_id_flush, id_ex_flush, pc_sel}
   localparam logic [7:0] C_RUN    = 8'b11111_000;
   localparam logic [7:0] C_FREEZE = 8'b00000_000;
   localparam logic [7:0] C_REDIR  = 8'b11111_111;
   localparam logic [7:0] C_LU     = 8'b00111_010;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [4:0]  id_rs1, id_rs2, ex_rs1, ex_rs2, ex_rd, mem_rd, wb_rd;
   logic        id_uses_rs1, id_uses_rs2, ex_reg_write, ex_is_load;
   logic        mem_reg_write, wb_reg_write, mem_access, dmem_ready, ex_branch;
   logic [31:0] ex_pc_branch;
   logic        pc_write, if_id_write, id_ex_write, ex_mem_write, mem_wb_write;
   logic        if_id_flush, id_ex_flush, pc_sel, mem_timeout;
   logic [31:0] pc_target;
   logic [1:0]  fwd_a, fwd_b, stall_state;

   int n_chk  = 0;
   int n_fail = 0;

   always #5 clk = ~clk;

   pipeline_ctrl #(.MEM_TIMEOUT(TMO), .CNT_W(32)) dut (
      .clk(clk), .rst_n(rst_n),
      .id_rs1(id_rs1), .id_rs2(id_rs2), .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2),
      .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .ex_rd(ex_rd),
      .ex_reg_write(ex_reg_write), .ex_is_load(ex_is_load),
      .mem_rd(mem_rd), .wb_rd(wb_rd), .mem_reg_write(mem_reg_write), .wb_reg_write(wb_reg_write),
      .mem_access(mem_access), .dmem_ready(dmem_ready),
      .ex_branch(ex_branch), .ex_pc_branch(ex_pc_branch),
      .pc_write(pc_write), .if_id_write(if_id_write), .id_ex_write(id_ex_write),
      .ex_mem_write(ex_mem_write), .mem_wb_write(mem_wb_write),
      .if_id_flush(if_id_flush), .id_ex_flush(id_ex_flush),
      .pc_sel(pc_sel), .pc_target(pc_target),
      .fwd_a(fwd_a), .fwd_b(fwd_b), .stall_state(stall_state), .mem_timeout(mem_timeout)
   );

   function automatic logic [7:0] ctl();
      return {pc_write, if_id_write, id_ex_write, ex_mem_write, mem_wb_write,
              if_id_flush, id_ex_flush, pc_sel};
   endfunction

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
      n_chk++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, req, $time);
      end
   endtask

   task automatic idle();
      id_rs1 = 5'd0; id_rs2 = 5'd0; id_uses_rs1 = 1'b0; id_uses_rs2 = 1'b0;
      ex_rs1 = 5'd0; ex_rs2 = 5'd0; ex_rd = 5'd0; ex_reg_write = 1'b0; ex_is_load = 1'b0;
      mem_rd = 5'd0; wb_rd = 5'd0; mem_reg_write = 1'b0; wb_reg_write = 1'b0;
      mem_access = 1'b0; dmem_ready = 1'b0; ex_branch = 1'b0; ex_pc_branch = 32'd0;
   endtask

   function automatic logic [1:0] ref_fwd(input logic [4:0] rs);
      if (mem_reg_write && mem_rd != 0 && mem_rd == rs) return 2'b10;
      if (wb_reg_write && wb_rd != 0 && wb_rd == rs) return 2'b01;
      return 2'b00;
   endfunction

   typedef struct {
      logic       mrw;
      logic [4:0] mrd;
      logic       wrw;
      logic [4:0] wrd;
      logic [4:0] rs1;
      logic [4:0] rs2;
      logic [1:0] ea;
      logic [1:0] eb;
   } fwd_vec_t;

   fwd_vec_t tbl[7];

   // Reference model state: waiting on memory, in the post-load-use cycle, wait length, sticky flag, held target.
   bit          m_wait, m_lu, m_to;
   int          m_cnt;
   logic [31:0] m_tgt;

   initial begin
      bit          hz, fr, rd, lu;
      logic [7:0]  e_ctl;
      logic [31:0] e_tgt;
      logic [1:0]  e_st;

      tbl[0] = '{1'b1, 5'd5,  1'b1, 5'd5,  5'd5,  5'd0,  2'b10, 2'b00};
      tbl[1] = '{1'b1, 5'd0,  1'b1, 5'd5,  5'd5,  5'd0,  2'b01, 2'b00};
      tbl[2] = '{1'b1, 5'd0,  1'b1, 5'd0,  5'd0,  5'd0,  2'b00, 2'b00};
      tbl[3] = '{1'b0, 5'd5,  1'b1, 5'd5,  5'd5,  5'd5,  2'b01, 2'b01};
      tbl[4] = '{1'b1, 5'd3,  1'b1, 5'd9,  5'd9,  5'd3,  2'b01, 2'b10};
      tbl[5] = '{1'b1, 5'd31, 1'b0, 5'd31, 5'd31, 5'd31, 2'b10, 2'b10};
      tbl[6] = '{1'b0, 5'd5,  1'b0, 5'd5,  5'd5,  5'd5,  2'b00, 2'b00};

      // Reset holds run defaults even with a pending memory wait and a redirect on the inputs.
      idle();
      rst_n = 1'b0;
      mem_access = 1'b1; ex_branch = 1'b1; ex_pc_branch = 32'h1234;
      #2;
      chk("reset_ctl", 64'(ctl()), 64'(C_RUN));
      chk("reset_tgt", 64'(pc_target), 64'd0);
      chk("reset_state", 64'(stall_state), 64'd0);
      chk("reset_tmo", 64'(mem_timeout), 64'd0);
      @(negedge clk);
      idle();
      rst_n = 1'b1;
      @(negedge clk);

      for (int i = 0; i < 7; i++) begin
         mem_reg_write = tbl[i].mrw; mem_rd = tbl[i].mrd;
         wb_reg_write  = tbl[i].wrw; wb_rd  = tbl[i].wrd;
         ex_rs1 = tbl[i].rs1; ex_rs2 = tbl[i].rs2;
         #1;
         chk($sformatf("fwd_a[%0d]", i), 64'(fwd_a), 64'(tbl[i].ea));
         chk($sformatf("fwd_b[%0d]", i), 64'(fwd_b), 64'(tbl[i].eb));
      end
      idle();
      @(negedge clk);

      // Load-use: one stall cycle, then LU_STALL with hazard still visible but not re-evaluated.
      ex_is_load = 1'b1; ex_reg_write = 1'b1; ex_rd = 5'd7; id_rs2 = 5'd7; id_uses_rs2 = 1'b1;
      #1;
      chk("lu_ctl", 64'(ctl()), 64'(C_LU));
      chk("lu_state0", 64'(stall_state), 64'd0);
      @(negedge clk); #1;
      chk("lu_state1", 64'(stall_state), 64'd1);
      chk("lu_ctl1", 64'(ctl()), 64'(C_RUN));
      @(negedge clk);
      idle(); #1;
      chk("lu_state2", 64'(stall_state), 64'd0);
      @(negedge clk);

      // Redirect beats a simultaneous load-use hazard.
      ex_is_load = 1'b1; ex_reg_write = 1'b1; ex_rd = 5'd7; id_rs1 = 5'd7; id_uses_rs1 = 1'b1;
      ex_branch = 1'b1; ex_pc_branch = 32'h0000_0040;
      #1;
      chk("redir_ctl", 64'(ctl()), 64'(C_REDIR));
      chk("redir_tgt", 64'(pc_target), 64'h40);
      @(negedge clk);
      idle(); ex_pc_branch = 32'h99; #1;
      chk("redir_state", 64'(stall_state), 64'd0);
      chk("redir_hold_tgt", 64'(pc_target), 64'h40);
      chk("redir_ctl_after", 64'(ctl()), 64'(C_RUN));
      @(negedge clk);

      // Memory wait masks a taken branch for 3 cycles; branch takes effect on release.
      mem_access = 1'b1; dmem_ready = 1'b0; ex_branch = 1'b1; ex_pc_branch = 32'h80;
      for (int i = 0; i < 3; i++) begin
         #1;
         chk($sformatf("mw_ctl[%0d]", i), 64'(ctl()), 64'(C_FREEZE));
         chk($sformatf("mw_state[%0d]", i), 64'(stall_state), (i == 0) ? 64'd0 : 64'd2);
         @(negedge clk);
      end
      dmem_ready = 1'b1; #1;
      chk("mw_release_ctl", 64'(ctl()), 64'(C_REDIR));
      chk("mw_release_tgt", 64'(pc_target), 64'h80);
      @(negedge clk);
      idle(); #1;
      chk("mw_exit_state", 64'(stall_state), 64'd0);
      chk("mw_no_tmo", 64'(mem_timeout), 64'd0);
      @(negedge clk);

      // Timeout: 6 not-ready cycles, flag from the 4th MEM_WAIT cycle and sticky afterwards.
      mem_access = 1'b1; dmem_ready = 1'b0;
      for (int i = 0; i < 6; i++) begin
         #1;
         chk($sformatf("tmo[%0d]", i), 64'(mem_timeout), (i >= 4) ? 64'd1 : 64'd0);
         @(negedge clk);
      end
      dmem_ready = 1'b1; #1;
      chk("tmo_release_ctl", 64'(ctl()), 64'(C_RUN));
      @(negedge clk);
      idle(); #1;
      chk("tmo_sticky", 64'(mem_timeout), 64'd1);
      chk("tmo_state", 64'(stall_state), 64'd0);
      @(negedge clk);

      // A new wait with the flag already set still stalls; then reset mid-wait.
      mem_access = 1'b1; dmem_ready = 1'b0;
      @(negedge clk); #1;
      chk("tmo_stall_state", 64'(stall_state), 64'd2);
      chk("tmo_stall_ctl", 64'(ctl()), 64'(C_FREEZE));
      @(negedge clk);
      rst_n = 1'b0; #1;
      chk("rst_mid_state", 64'(stall_state), 64'd0);
      chk("rst_mid_ctl", 64'(ctl()), 64'(C_RUN));
      chk("rst_mid_tmo", 64'(mem_timeout), 64'd0);
      chk("rst_mid_tgt", 64'(pc_target), 64'd0);
      @(negedge clk);
      rst_n = 1'b1;
      // Counter restarted from 0: flag appears only after a full timeout again.
      for (int i = 0; i < 5; i++) begin
         #1;
         chk($sformatf("rst_cnt[%0d]", i), 64'(mem_timeout), (i >= 4) ? 64'd1 : 64'd0);
         @(negedge clk);
      end

      // Randomized traffic against the reference model, starting from a fresh reset.
      idle();
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      m_wait = 0; m_lu = 0; m_to = 0; m_cnt = 0; m_tgt = 32'd0;
      for (int c = 0; c < 3000; c++) begin
         id_rs1 = 5'($urandom_range(0, 3)); id_rs2 = 5'($urandom_range(0, 3));
         id_uses_rs1 = 1'($urandom); id_uses_rs2 = 1'($urandom);
         ex_rs1 = 5'($urandom_range(0, 3)); ex_rs2 = 5'($urandom_range(0, 3));
         ex_rd = 5'($urandom_range(0, 3));
         ex_reg_write = ($urandom_range(0, 3) != 0); ex_is_load = 1'($urandom);
         mem_rd = 5'($urandom_range(0, 3)); wb_rd = 5'($urandom_range(0, 3));
         mem_reg_write = 1'($urandom); wb_reg_write = 1'($urandom);
         mem_access = ($urandom_range(0, 2) == 0); dmem_ready = ($urandom_range(0, 3) != 0);
         ex_branch = ($urandom_range(0, 4) == 0); ex_pc_branch = $urandom & 32'hFFFF_FFFC;
         #1;
         hz = ex_is_load && ex_reg_write && ex_rd != 0 &&
              ((id_uses_rs1 && id_rs1 == ex_rd) || (id_uses_rs2 && id_rs2 == ex_rd));
         fr = m_wait ? !dmem_ready : (mem_access && !dmem_ready);
         rd = !fr && ex_branch;
         lu = !fr && !rd && !m_lu && hz;
         e_ctl = {!fr && !lu, !fr && !lu, !fr, !fr, !fr, rd, rd || lu, rd};
         e_tgt = rd ? ex_pc_branch : m_tgt;
         e_st  = m_wait ? 2'd2 : (m_lu ? 2'd1 : 2'd0);
         chk("rand_ctl", 64'(ctl()), 64'(e_ctl));
         chk("rand_tgt", 64'(pc_target), 64'(e_tgt));
         chk("rand_state", 64'(stall_state), 64'(e_st));
         chk("rand_tmo", 64'(mem_timeout), 64'(m_to));
         chk("rand_fwd", 64'({fwd_a, fwd_b}), 64'({ref_fwd(ex_rs1), ref_fwd(ex_rs2)}));
         m_tgt  = e_tgt;
         m_wait = fr;
         m_lu   = lu;
         m_cnt  = fr ? ((m_cnt < TMO) ? m_cnt + 1 : m_cnt) : 0;
         if (m_cnt == TMO) m_to = 1;
         @(negedge clk);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
